// File: rtl/cnn_pkg.sv
// Shared constants for the layer instruction sequencer: opcodes, FSM states,
// and control/status register bit positions.
package cnn_pkg;

  localparam int unsigned INST_COMPUTE_DEF    = 87;
  localparam int unsigned INST_LOADIFMAPS_DEF = 88;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_COMPUTE = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  localparam int unsigned CTRL1_POOL_BIT  = 0;
  localparam int unsigned CTRL1_LEN_LSB   = 16;
  localparam int unsigned CTRL2_ACK_BIT   = 5;

  localparam int unsigned STAT_BUSY       = 0;
  localparam int unsigned STAT_DONE       = 1;
  localparam int unsigned STAT_ERR_KERNEL = 2;
  localparam int unsigned STAT_ERR_OVF    = 3;
  localparam int unsigned STAT_STATE_LSB  = 4;
  localparam int unsigned STAT_WORDS_LSB  = 16;

endpackage

// File: rtl/kernel_onehot_decode.sv
// Converts the one-hot kernel-size field into K and K*K; valid only when
// exactly one of the five bits is set.
module kernel_onehot_decode (
  input  logic [4:0] onehot,
  output logic [2:0] k,
  output logic [4:0] kk,
  output logic       valid
);

  always_comb begin
    k     = '0;
    kk    = '0;
    valid = 1'b0;
    unique case (onehot)
      5'b00001: begin k = 3'd1; kk = 5'd1;  valid = 1'b1; end
      5'b00010: begin k = 3'd2; kk = 5'd4;  valid = 1'b1; end
      5'b00100: begin k = 3'd3; kk = 5'd9;  valid = 1'b1; end
      5'b01000: begin k = 3'd4; kk = 5'd16; valid = 1'b1; end
      5'b10000: begin k = 3'd5; kk = 5'd25; valid = 1'b1; end
      default:  begin k = '0;   kk = '0;    valid = 1'b0; end
    endcase
  end

endmodule

// File: rtl/layer_inst_sequencer.sv
// Decodes AXI-Lite control words into ifmap loads and convolution/pooling
// compute passes, driving the BRAM ports and MAC strobes, and reports status.
module layer_inst_sequencer
  import cnn_pkg::*;
#(
  parameter int unsigned BRAM_ADDRESS_WIDTH   = 12,
  parameter int unsigned C_S_AXIS_TDATA_WIDTH = 32,
  parameter int unsigned RD_LAT               = 1,
  parameter int unsigned MAC_LAT              = 2,
  parameter int unsigned INST_COMPUTE         = INST_COMPUTE_DEF,
  parameter int unsigned INST_LOADIFMAPS      = INST_LOADIFMAPS_DEF
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0] axi_control_0,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0] axi_control_1,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0] axi_control_2,
  output logic [C_S_AXIS_TDATA_WIDTH-1:0] axi_control_3,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0] S_AXIS_TDATA,
  input  logic                            S_AXIS_TVALID,
  input  logic                            S_AXIS_TLAST,
  output logic                            S_AXIS_TREADY,
  output logic                            bram_we,
  output logic [BRAM_ADDRESS_WIDTH-1:0]   bram_waddr,
  output logic [C_S_AXIS_TDATA_WIDTH-1:0] bram_wdata,
  output logic                            bram_re,
  output logic [BRAM_ADDRESS_WIDTH-1:0]   bram_raddr,
  output logic                            mac_en,
  output logic                            mac_clear,
  output logic                            mac_pool,
  output logic                            psum_valid
);

  localparam int unsigned AW        = BRAM_ADDRESS_WIDTH;
  localparam int unsigned DW        = C_S_AXIS_TDATA_WIDTH;
  // Cycles spent in DRAIN so psum_valid lands K*K+RD_LAT+MAC_LAT after accept.
  localparam int unsigned DRAIN_CYC = RD_LAT + MAC_LAT - 1;
  localparam int unsigned DCW       = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  localparam logic [DW-1:0]  OP_COMPUTE = DW'(INST_COMPUTE);
  localparam logic [DW-1:0]  OP_LOAD    = DW'(INST_LOADIFMAPS);
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_CYC - 1);

  state_e             state_q, state_d;
  logic [DW-1:0]      prev_op_q, prev_op_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [15:0]        len_q, len_d;
  logic [4:0]         kk_q, kk_d;
  logic [AW-1:0]      raddr_q, raddr_d;
  logic               re_q, re_d;
  logic               we_q, we_d;
  logic [AW-1:0]      waddr_q, waddr_d;
  logic [DW-1:0]      wdata_q, wdata_d;
  logic [RD_LAT-1:0]  en_sr_q, en_sr_d;
  logic [RD_LAT-1:0]  clr_sr_q, clr_sr_d;
  logic               pool_q, pool_d;
  logic               psum_q, psum_d;
  logic [DCW-1:0]     drain_q, drain_d;
  logic               err_k_q, err_k_d;
  logic               err_ovf_q, err_ovf_d;

  logic [2:0]         dec_k;
  logic [4:0]         dec_kk;
  logic               dec_valid;
  logic               op_new;
  logic [15:0]        cnt_inc;
  logic [AW-1:0]      last_raddr;
  logic               unused_bits;

  kernel_onehot_decode u_kdec (
    .onehot (axi_control_2[4:0]),
    .k      (dec_k),
    .kk     (dec_kk),
    .valid  (dec_valid)
  );

  assign op_new      = (axi_control_0 != prev_op_q);
  assign cnt_inc     = cnt_q + 16'd1;
  assign last_raddr  = AW'(kk_q) - AW'(1);
  assign unused_bits = ^{axi_control_1[DW-1:0], axi_control_2[DW-1:6], dec_k};

  always_comb begin
    state_d   = state_q;
    prev_op_d = axi_control_0;
    cnt_d     = cnt_q;
    len_d     = len_q;
    kk_d      = kk_q;
    raddr_d   = raddr_q;
    re_d      = 1'b0;
    we_d      = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    pool_d    = pool_q;
    psum_d    = 1'b0;
    drain_d   = drain_q;
    err_k_d   = err_k_q;
    err_ovf_d = err_ovf_q;
    en_sr_d    = en_sr_q << 1;
    en_sr_d[0] = re_q;
    clr_sr_d    = clr_sr_q << 1;
    clr_sr_d[0] = re_q && (raddr_q == '0);

    unique case (state_q)
      ST_IDLE: begin
        if (op_new && axi_control_0 == OP_COMPUTE) begin
          err_k_d   = ~dec_valid;
          err_ovf_d = 1'b0;
          if (dec_valid) begin
            kk_d    = dec_kk;
            pool_d  = axi_control_1[CTRL1_POOL_BIT];
            raddr_d = '0;
            re_d    = 1'b1;
            state_d = ST_COMPUTE;
          end
        end else if (op_new && axi_control_0 == OP_LOAD) begin
          err_k_d   = 1'b0;
          err_ovf_d = 1'b0;
          cnt_d     = '0;
          len_d     = axi_control_1[CTRL1_LEN_LSB +: 16];
          state_d   = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (S_AXIS_TVALID) begin
          we_d    = 1'b1;
          waddr_d = cnt_q[AW-1:0];
          wdata_d = S_AXIS_TDATA;
          cnt_d   = cnt_inc;
          // Top address is still written; the load then stops instead of wrapping.
          if (&cnt_q[AW-1:0]) begin
            err_ovf_d = 1'b1;
            state_d   = ST_DONE;
          end else if (S_AXIS_TLAST || (len_q != '0 && cnt_inc == len_q)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_COMPUTE: begin
        if (raddr_q == last_raddr) begin
          drain_d = '0;
          state_d = ST_DRAIN;
        end else begin
          raddr_d = raddr_q + AW'(1);
          re_d    = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          psum_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          drain_d = drain_q + DCW'(1);
        end
      end
      ST_DONE: begin
        if (axi_control_2[CTRL2_ACK_BIT]) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      prev_op_q <= '0;
      cnt_q     <= '0;
      len_q     <= '0;
      kk_q      <= '0;
      raddr_q   <= '0;
      re_q      <= 1'b0;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      en_sr_q   <= '0;
      clr_sr_q  <= '0;
      pool_q    <= 1'b0;
      psum_q    <= 1'b0;
      drain_q   <= '0;
      err_k_q   <= 1'b0;
      err_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_op_q <= prev_op_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      kk_q      <= kk_d;
      raddr_q   <= raddr_d;
      re_q      <= re_d;
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      en_sr_q   <= en_sr_d;
      clr_sr_q  <= clr_sr_d;
      pool_q    <= pool_d;
      psum_q    <= psum_d;
      drain_q   <= drain_d;
      err_k_q   <= err_k_d;
      err_ovf_q <= err_ovf_d;
    end
  end

  always_comb begin
    axi_control_3                              = '0;
    axi_control_3[STAT_BUSY]                   = (state_q == ST_LOAD) || (state_q == ST_COMPUTE) ||
                                                 (state_q == ST_DRAIN);
    axi_control_3[STAT_DONE]                   = (state_q == ST_DONE);
    axi_control_3[STAT_ERR_KERNEL]             = err_k_q;
    axi_control_3[STAT_ERR_OVF]                = err_ovf_q;
    axi_control_3[STAT_STATE_LSB +: 3]         = state_q;
    axi_control_3[STAT_WORDS_LSB +: 16]        = cnt_q;
  end

  assign S_AXIS_TREADY = (state_q == ST_LOAD);
  assign bram_we       = we_q;
  assign bram_waddr    = waddr_q;
  assign bram_wdata    = wdata_q;
  assign bram_re       = re_q;
  assign bram_raddr    = raddr_q;
  assign mac_en        = en_sr_q[RD_LAT-1];
  assign mac_clear     = clr_sr_q[RD_LAT-1];
  assign mac_pool      = pool_q;
  assign psum_valid    = psum_q;

endmodule

// File: tb/tb_layer_inst_sequencer.sv
// Self-checking bench for layer_inst_sequencer: table of compute commands,
// hand-written corner sequences, and randomized loads/computes against a model.
module tb_layer_inst_sequencer;

  localparam int unsigned AW      = 12;
  localparam int unsigned DW      = 32;
  localparam int unsigned RD_LAT  = 1;
  localparam int unsigned MAC_LAT = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] axi_control_0, axi_control_1, axi_control_2, axi_control_3;
  logic [DW-1:0] S_AXIS_TDATA;
  logic          S_AXIS_TVALID, S_AXIS_TLAST, S_AXIS_TREADY;
  logic          bram_we, bram_re, mac_en, mac_clear, mac_pool, psum_valid;
  logic [AW-1:0] bram_waddr, bram_raddr;
  logic [DW-1:0] bram_wdata;

  layer_inst_sequencer #(
    .BRAM_ADDRESS_WIDTH   (AW),
    .C_S_AXIS_TDATA_WIDTH (DW),
    .RD_LAT               (RD_LAT),
    .MAC_LAT              (MAC_LAT),
    .INST_COMPUTE         (87),
    .INST_LOADIFMAPS      (88)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .axi_control_0 (axi_control_0),
    .axi_control_1 (axi_control_1),
    .axi_control_2 (axi_control_2),
    .axi_control_3 (axi_control_3),
    .S_AXIS_TDATA  (S_AXIS_TDATA),
    .S_AXIS_TVALID (S_AXIS_TVALID),
    .S_AXIS_TLAST  (S_AXIS_TLAST),
    .S_AXIS_TREADY (S_AXIS_TREADY),
    .bram_we       (bram_we),
    .bram_waddr    (bram_waddr),
    .bram_wdata    (bram_wdata),
    .bram_re       (bram_re),
    .bram_raddr    (bram_raddr),
    .mac_en        (mac_en),
    .mac_clear     (mac_clear),
    .mac_pool      (mac_pool),
    .psum_valid    (psum_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       pool;
    logic [4:0] kern;
    int         reads;
    logic       err;
  } vec_t;

  vec_t          vecs[7];
  int            checks, errors;
  int            cyc, re_cnt, raddr_bad, first_re, last_re, en_cnt, first_en;
  int            clr_cnt, clr_cyc, clr_no_en, psum_cnt, psum_cyc;
  logic [AW-1:0] wr_addr_q[$];
  logic [DW-1:0] wr_data_q[$];
  logic [DW-1:0] ld_data[4200];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic clear_log();
    cyc = 0; re_cnt = 0; raddr_bad = 0; first_re = 0; last_re = 0; en_cnt = 0; first_en = 0;
    clr_cnt = 0; clr_cyc = 0; clr_no_en = 0; psum_cnt = 0; psum_cyc = 0;
    wr_addr_q.delete(); wr_data_q.delete();
  endtask

  task automatic tick();
    @(posedge clk); #1;
    cyc++;
    if (bram_re) begin
      if (int'(bram_raddr) != re_cnt) raddr_bad++;
      re_cnt++;
      if (first_re == 0) first_re = cyc;
      last_re = cyc;
    end
    if (mac_en) begin
      en_cnt++;
      if (first_en == 0) first_en = cyc;
    end
    if (mac_clear) begin
      clr_cnt++; clr_cyc = cyc;
      if (!mac_en) clr_no_en++;
    end
    if (psum_valid) begin psum_cnt++; psum_cyc = cyc; end
    if (bram_we) begin wr_addr_q.push_back(bram_waddr); wr_data_q.push_back(bram_wdata); end
  endtask

  // Reference rule: a kernel field is legal only with exactly one bit set; K is that bit's position + 1.
  function automatic int kernel_reads(input logic [4:0] oh);
    int k = 0;
    if ($countones(oh) != 1) return -1;
    for (int b = 0; b < 5; b++) if (oh[b]) k = b + 1;
    return k * k;
  endfunction

  task automatic ack();
    axi_control_2[5] = 1'b1;
    tick();
    axi_control_2[5] = 1'b0;
  endtask

  task automatic start_compute(input logic pool, input logic [4:0] kern);
    axi_control_0 = 0;
    tick();
    axi_control_1 = {31'd0, pool};
    axi_control_2 = {27'd0, kern};
    axi_control_0 = 87;
    clear_log();
  endtask

  task automatic check_compute(input string tag, input logic pool, input logic [4:0] kern);
    int reads = kernel_reads(kern);
    if (reads > 0) begin
      check({tag, "_reads"},     re_cnt, reads);
      check({tag, "_raddr"},     raddr_bad, 0);
      check({tag, "_re_window"}, {first_re[15:0], last_re[15:0]}, {16'd1, reads[15:0]});
      check({tag, "_mac_en"},    {en_cnt[15:0], first_en[15:0]}, {reads[15:0], 16'(1 + RD_LAT)});
      check({tag, "_mac_clear"}, {clr_cnt[7:0], clr_cyc[15:0], clr_no_en[7:0]}, {8'd1, 16'(1 + RD_LAT), 8'd0});
      check({tag, "_psum"},      {psum_cnt[15:0], psum_cyc[15:0]}, {16'd1, 16'(reads + RD_LAT + MAC_LAT)});
      check({tag, "_pool"},      mac_pool, pool);
      check({tag, "_status"},    axi_control_3[6:0], {3'd4, 4'b0010});
    end else begin
      check({tag, "_err_reads"}, {re_cnt[15:0], psum_cnt[15:0]}, 0);
      check({tag, "_err_status"}, axi_control_3[6:0], {3'd0, 4'b0100});
    end
  endtask

  task automatic run_load(input string tag, input int nwords, input logic [15:0] len,
                          input int last_idx, input int vprob, input int max_cyc);
    int idx = 0, n = 0, exp_n, bad = 0;
    logic v;
    axi_control_0 = 0;
    tick();
    axi_control_1 = {len, 16'd0};
    axi_control_0 = 88;
    clear_log();
    tick();
    while (S_AXIS_TREADY && n < max_cyc) begin
      v = (($urandom_range(0, 99) < vprob) && idx < nwords);
      S_AXIS_TVALID = v;
      S_AXIS_TDATA  = ld_data[idx];
      S_AXIS_TLAST  = v && (idx == last_idx);
      tick();
      n++;
      if (v) idx++;
    end
    S_AXIS_TVALID = 1'b0;
    S_AXIS_TLAST  = 1'b0;
    tick();
    check({tag, "_bounded"}, S_AXIS_TREADY, 0);
    exp_n = (last_idx < nwords) ? last_idx + 1 : nwords;
    if (len != 0 && int'(len) < exp_n) exp_n = int'(len);
    if (exp_n > 4096) exp_n = 4096;
    for (int i = 0; i < wr_addr_q.size(); i++)
      if (int'(wr_addr_q[i]) != i || wr_data_q[i] !== ld_data[i]) bad++;
    check({tag, "_writes"}, wr_addr_q.size(), exp_n);
    check({tag, "_wdata"}, bad, 0);
    check({tag, "_beats"}, idx, exp_n);
    check({tag, "_status"}, {axi_control_3[31:16], axi_control_3[6:0]},
          {exp_n[15:0], 3'd4, (exp_n == 4096), 3'b010});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1;
    axi_control_0 = 0; axi_control_1 = 0; axi_control_2 = 0;
    S_AXIS_TDATA = 0; S_AXIS_TVALID = 1'b0; S_AXIS_TLAST = 1'b0;
    clear_log();

    vecs[0] = '{1'b0, 5'b10000, 25, 1'b0};
    vecs[1] = '{1'b1, 5'b00100,  9, 1'b0};
    vecs[2] = '{1'b0, 5'b00001,  1, 1'b0};
    vecs[3] = '{1'b1, 5'b00010,  4, 1'b0};
    vecs[4] = '{1'b0, 5'b01000, 16, 1'b0};
    vecs[5] = '{1'b0, 5'b00110,  0, 1'b1};
    vecs[6] = '{1'b1, 5'b00000,  0, 1'b1};

    tick(); tick();
    check("rst_status", axi_control_3, 0);
    check("rst_outs", {S_AXIS_TREADY, bram_we, bram_waddr, bram_re, bram_raddr, mac_en, mac_clear,
                       mac_pool, psum_valid}, 0);
    check("rst_wdata", bram_wdata, 0);
    rst = 1'b0;
    tick();

    foreach (vecs[i]) begin
      start_compute(vecs[i].pool, vecs[i].kern);
      repeat (40) tick();
      check($sformatf("vec%0d_reads", i), re_cnt, vecs[i].reads);
      check($sformatf("vec%0d_err", i), axi_control_3[2], vecs[i].err);
      check_compute($sformatf("vec%0d", i), vecs[i].pool, vecs[i].kern);
      ack();
      check($sformatf("vec%0d_idle", i), axi_control_3[6:4], 0);
    end

    // Illegal kernel, then held opcode must not re-fire even with a legal kernel.
    start_compute(1'b0, 5'b00110);
    repeat (5) tick();
    check("badk_status", axi_control_3[6:0], {3'd0, 4'b0100});
    axi_control_2 = {27'd0, 5'b10000};
    repeat (10) tick();
    check("held_no_refire", re_cnt, 0);
    check("held_err_sticky", axi_control_3[2], 1);
    start_compute(1'b0, 5'b10000);
    repeat (40) tick();
    check_compute("rearm", 1'b0, 5'b10000);
    ack();

    // POOL K=3 with an ack pulse mid-COMPUTE that must be ignored.
    start_compute(1'b1, 5'b00100);
    repeat (3) tick();
    check("pool_busy", axi_control_3[0], 1);
    ack();
    repeat (20) tick();
    check_compute("pool_ack_ignored", 1'b1, 5'b00100);
    ack();
    check("pool_ack_idle", axi_control_3[1:0], 0);

    // Load terminated by TLAST.
    for (int i = 0; i < 7; i++) ld_data[i] = 123 + i;
    run_load("load_tlast", 7, 16'd0, 6, 100, 100);
    ack();
    check("load_ack_idle", axi_control_3[6:4], 0);

    // Length-limited load ends before TLAST.
    for (int i = 0; i < 12; i++) ld_data[i] = $urandom;
    run_load("load_len", 12, 16'd5, 11, 70, 200);
    ack();

    // Endless stream overflows at the last BRAM address.
    for (int i = 0; i < 4200; i++) ld_data[i] = $urandom;
    run_load("load_ovf", 4200, 16'd0, 9999, 100, 5000);
    check("ovf_last_addr", wr_addr_q[$], 4095);
    ack();
    start_compute(1'b0, 5'b00010);
    repeat (12) tick();
    check("ovf_cleared", axi_control_3[3:0], 4'b0010);
    ack();

    // Reset mid-COMPUTE: immediate IDLE, no psum_valid afterwards.
    start_compute(1'b0, 5'b10000);
    repeat (10) tick();
    rst = 1'b1;
    axi_control_0 = 0;
    tick();
    check("midrst_status", axi_control_3, 0);
    check("midrst_outs", {bram_re, mac_en, psum_valid}, 0);
    rst = 1'b0;
    clear_log();
    repeat (40) tick();
    check("midrst_quiet", {re_cnt[15:0], psum_cnt[15:0]}, 0);

    for (int r = 0; r < 20; r++) begin
      logic [4:0] kern;
      logic       pool;
      pool = 1'($urandom_range(0, 1));
      kern = ($urandom_range(0, 3) != 0) ? 5'(1 << $urandom_range(0, 4)) : 5'($urandom);
      start_compute(pool, kern);
      repeat (40) tick();
      check_compute($sformatf("rnd_c%0d", r), pool, kern);
      ack();
    end

    for (int r = 0; r < 20; r++) begin
      int nw, li;
      logic [15:0] len;
      nw  = $urandom_range(1, 20);
      li  = $urandom_range(0, nw - 1);
      len = ($urandom_range(0, 2) == 0) ? 16'd0 : 16'($urandom_range(1, 25));
      for (int i = 0; i < nw; i++) ld_data[i] = $urandom;
      run_load($sformatf("rnd_l%0d", r), nw, len, li, 60, 400);
      ack();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
